sequenciador_programa: RTL
==========================

# sequenciador_programa

Program sequencer sitting directly upstream of the multicycle processor. It reads 16-bit words from a synchronous program ROM, presents each instruction on the processor's `DIN` with a one-cycle `Run` pulse, and supplies the immediate word for `mvi`. It then waits for the processor's `Done` before fetching the next instruction. Execution stops on the reserved halt opcode.

## Interface

Parameters:
- `ADDR_W`, 5, ROM address width; PC wraps modulo 2^ADDR_W
- `TIMEOUT`, 15, max cycles in `S_EXECUTA` without `Done` (used only with watchdog compiled in)

Ports:
- `Clock`  in  1  single clock, all state updates on rising edge
- `Resetn`  in  1  synchronous, active-low reset
- `Start`  in  1  begin execution from the current PC; sampled only in `S_IDLE` and `S_HALT`
- `MemData`  in  16  ROM read data, valid the cycle after `Addr` is presented
- `Done`  in  1  processor instruction complete; sampled only in `S_EXECUTA`
- `Addr`  out  ADDR_W  ROM address
- `DIN`  out  16  word driven to the processor `DIN`
- `Run`  out  1  one-cycle pulse, processor latches `DIN[8:0]` into IR
- `Busy`  out  1  high in every state except `S_IDLE`, `S_HALT`, `S_ERRO`
- `Halted`  out  1  high in `S_HALT`
- `Erro`  out  1  watchdog tripped (sticky)

## Operation

- Instruction format is `DIN[8:0]` = IIIXXXYYY. Opcode `DIN[8:6]`: 000 mv, 001 mvi, 010 add, 011 sub, 111 halt (sequencer only, never issued). Other opcodes are issued as-is.
- Internal registers:
  - `PC[ADDR_W-1:0]`
  - `instr[15:0]`
  - `imed[15:0]`
- `Addr` is always equal to `PC`.
- FSM:
  - `S_IDLE`: `Start` → `S_BUSCA`.
  - `S_BUSCA`: ROM samples `Addr`. Go to `S_CAPTURA`.
  - `S_CAPTURA`: `instr <= MemData`, `PC <= PC+1`. Opcode 111 → `S_HALT`; 001 → `S_BUSCA_IMED`; else → `S_EMITE`.
  - `S_BUSCA_IMED`: ROM samples `Addr` (=immediate address). Go to `S_CAPTURA_IMED`.
  - `S_CAPTURA_IMED`: `imed <= MemData`, `PC <= PC+1`. Go to `S_EMITE`.
  - `S_EMITE`: `Run=1`, `DIN=instr`. Go to `S_EXECUTA`.
  - `S_EXECUTA`: `Run=0`. `DIN=imed` if opcode 001, else `DIN=instr`. `Done` → `S_BUSCA`.
  - `S_HALT`: `Halted=1`, `PC` holds the address after the halt word. `Start` → `S_BUSCA` (resume).
  - `S_ERRO`: exists only with the watchdog. Leaves only by reset.
- `DIN` outside `S_EMITE`/`S_EXECUTA` holds its last value. After reset it is 0.
- PC wrap: 2^ADDR_W−1 + 1 → 0, including the immediate fetch, so an `mvi` in the last slot reads its immediate from address 0.
- `Done` in any state other than `S_EXECUTA` is ignored. `Start` while `Busy` is ignored.

## Timing

- Reset (`Resetn`=0 at a rising edge, any state, including mid-execution) applies on that edge:
  - state `S_IDLE`
  - `PC`=0, `instr`=0, `imed`=0
  - `Addr`=0, `DIN`=0, `Run`=0, `Busy`=0, `Halted`=0, `Erro`=0
  - watchdog counter 0
- `Start` sampled high in cycle n → `Run`=1 in cycle n+3 (mv/add/sub) or n+5 (mvi).
- `Done` sampled high in cycle m → next `Run`=1 in cycle m+3 (or m+5 if the next instruction is mvi).
- `Run` is high for exactly one cycle per issued instruction.
- `DIN` is stable from the `Run` cycle until the cycle `Done` is sampled. For mvi, `DIN` switches to `imed` the cycle after `Run`, matching processor T1.
- `Done` in the same cycle as `Run` is impossible, because the processor's minimum latency is one cycle after T0. It is ignored anyway.

## Configuration

- `SEQUENCIADOR_WATCHDOG_EN` defined:
  - An 8-bit counter clears on entering `S_EXECUTA` and increments each cycle there.
  - If the counter reaches `TIMEOUT` without `Done`, the next state is `S_ERRO`, with `Erro`=1 and `Busy`=0.
  - `Done` in the same cycle the counter reaches `TIMEOUT` takes priority and goes to `S_BUSCA`.
- Not defined:
  - No counter and no `S_ERRO`; `Erro` is tied 0.
  - `S_EXECUTA` waits indefinitely.

## Test plan

- ROM[0]=0x0000 (mv R0,R0), `Start` pulse at cycle 2 → `Addr`=0, `Run`=1 at cycle 5 with `DIN`=0x0000. `Done` at cycle 8 → `Addr`=1 at cycle 9.
- ROM[0]=0x0048 (mvi R1), ROM[1]=0x1234, ROM[2]=0x01C0 (halt) → `Run` with `DIN`=0x0048, then `DIN`=0x1234 until `Done`. Then `Halted`=1, `PC`=3, `Busy`=0.
- ROM[31]=0x0040 (mvi R1), ROM[0]=0xBEEF, `PC` reaches 31 (`ADDR_W`=5) → `DIN`=0xBEEF after `Run`; `PC`=1 after capture.
- Assert `Resetn`=0 in `S_EXECUTA` with `DIN`=0x0050 → next cycle all outputs 0 and state `S_IDLE`. `Done` arriving afterwards is ignored.
- `Done` pulsed in `S_IDLE` and `S_CAPTURA`; `Start` pulsed in `S_EXECUTA` → no state change, no extra `Run`.
- Watchdog on, `TIMEOUT`=15, `Done` never asserted → `Erro`=1 on the 16th cycle after entering `S_EXECUTA`. It stays 1 despite `Start` until reset. With the macro off, the same stimulus keeps `Busy`=1 and `Erro`=0 indefinitely.

Source files
------------

// File: rtl/sequenciador_programa.sv
// sequenciador_programa: program sequencer feeding the multicycle processor.
// Fetches 16-bit words from a synchronous ROM, issues each one with a Run pulse
// and waits for Done.
//
// Ports:
//   Clock   - single clock; Resetn - synchronous active-low reset
//   Start   - begin/resume execution (S_IDLE, S_HALT only)
//   MemData - ROM data, valid one cycle after Addr
//   Done    - processor finished current instruction (S_EXECUTA only)
//   Addr    - ROM address (= PC)
//   DIN     - word presented to the processor
//   Run     - one-cycle issue pulse
//   Busy    - executing a program
//   Halted  - stopped on halt opcode (111)
//   Erro    - watchdog tripped, sticky until reset
//
// Optional feature: define SEQUENCIADOR_WATCHDOG_EN to enable the S_EXECUTA
// timeout (TIMEOUT cycles without Done -> S_ERRO).
module sequenciador_programa #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [15:0]       MemData,
    input  logic              Done,
    output logic [ADDR_W-1:0] Addr,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Erro
);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BUSCA,
        S_CAPTURA,
        S_BUSCA_IMED,
        S_CAPTURA_IMED,
        S_EMITE,
        S_EXECUTA,
        S_HALT
`ifdef SEQUENCIADOR_WATCHDOG_EN
        ,
        S_ERRO
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [15:0]       r_instr;
    logic [15:0]       r_imed;
    logic [15:0]       r_din;
    logic [2:0]        w_mem_op;
    logic              w_instr_mvi;

`ifdef SEQUENCIADOR_WATCHDOG_EN
    logic [7:0]        r_wd_cnt;
    logic              w_wd_expired;

    assign w_wd_expired = (r_wd_cnt == 8'(TIMEOUT));
`else
    logic              w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // Natural overflow gives the required wrap to address 0.
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_mem_op    = MemData[8:6];
    assign w_instr_mvi = (r_instr[8:6] == OP_MVI);

    assign Addr = r_pc;
    assign DIN  = r_din;

    // Next state and decoded outputs
    always_comb begin
        w_next = r_state;
        Run    = 1'b0;
        Busy   = 1'b1;
        Halted = 1'b0;
        Erro   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) w_next = S_BUSCA;
            end
            S_BUSCA: w_next = S_CAPTURA;
            S_CAPTURA: begin
                if (w_mem_op == OP_HALT)
                    w_next = S_HALT;
                else if (w_mem_op == OP_MVI)
                    w_next = S_BUSCA_IMED;
                else
                    w_next = S_EMITE;
            end
            S_BUSCA_IMED:   w_next = S_CAPTURA_IMED;
            S_CAPTURA_IMED: w_next = S_EMITE;
            S_EMITE: begin
                Run    = 1'b1;
                w_next = S_EXECUTA;
            end
            S_EXECUTA: begin
                // Done wins over an expiring watchdog.
                if (Done)
                    w_next = S_BUSCA;
`ifdef SEQUENCIADOR_WATCHDOG_EN
                else if (w_wd_expired)
                    w_next = S_ERRO;
`endif
            end
            S_HALT: begin
                Busy   = 1'b0;
                Halted = 1'b1;
                if (Start) w_next = S_BUSCA;
            end
`ifdef SEQUENCIADOR_WATCHDOG_EN
            S_ERRO: begin
                Busy = 1'b0;
                Erro = 1'b1;
            end
`endif
            default: begin
                Busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_imed  <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CAPTURA) begin
                r_instr <= MemData;
                r_pc    <= w_pc_inc;
                // Plain instructions go straight to S_EMITE, so load DIN now.
                if (w_next == S_EMITE) r_din <= MemData;
            end
            if (r_state == S_CAPTURA_IMED) begin
                r_imed <= MemData;
                r_pc   <= w_pc_inc;
                r_din  <= r_instr;
            end
            // Processor T1 for mvi wants the immediate on DIN.
            if (r_state == S_EMITE)
                r_din <= w_instr_mvi ? r_imed : r_instr;
        end
    end

`ifdef SEQUENCIADOR_WATCHDOG_EN
    always_ff @(posedge Clock) begin
        if (!Resetn)
            r_wd_cnt <= '0;
        else if (r_state == S_EMITE)
            r_wd_cnt <= '0;
        else if (r_state == S_EXECUTA)
            r_wd_cnt <= r_wd_cnt + 8'd1;
    end
`endif

endmodule
